seg_scan_mux: RTL

Parametrised, time-multiplexed seven-segment display driver. It replaces the fixed 4-way combinational pattern selector with a self-timed scanner. It stores one segment pattern per digit in tear-free shadow registers and steps through the digits at a programmable refresh rate. Each digit slot begins with an anti-ghosting blank interval, and output polarity is configurable. It sits between the digit encoders and the board's segment/anode pins.

---
 rtl/seg_scan_mux.sv | 117 +++++++++++
 1 files changed

// File: rtl/seg_scan_mux.sv
// Self-timed seven-segment scanner: tear-free shadow patterns, per-slot blanking,
// per-digit enables and configurable pin polarity. All outputs are registered.
module seg_scan_mux #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SEG_W        = 7,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_DIGITS*SEG_W-1:0]      seg_in,
  input  logic                             load,
  input  logic [NUM_DIGITS-1:0]            digit_en,
  output logic [SEG_W-1:0]                 seg_out,
  output logic [NUM_DIGITS-1:0]            an_out,
  output logic [$clog2(NUM_DIGITS)-1:0]    digit_idx,
  output logic                             pending,
  output logic                             frame_done
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned PAT_W = NUM_DIGITS * SEG_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [PAT_W-1:0]      shadow_q, shadow_d;
  logic [PAT_W-1:0]      pend_data_q, pend_data_d;
  logic                  pending_q, pending_d;
  logic                  frame_done_q, frame_done_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  boundary;

  // Scan counters, pending capture and frame-boundary shadow update
  always_comb begin
    cnt_d        = cnt_q + CNT_W'(1);
    idx_d        = idx_q;
    boundary     = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
    shadow_d     = shadow_q;
    pend_data_d  = pend_data_q;
    pending_d    = pending_q;
    frame_done_d = boundary;

    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
    if (boundary && pending_q) begin
      shadow_d = pend_data_q;
    end
    // A load on the boundary cycle re-arms the flag for the following frame
    if (load) begin
      pend_data_d = seg_in;
      pending_d   = 1'b1;
    end else if (boundary) begin
      pending_d = 1'b0;
    end

    if (rst) begin
      cnt_d        = '0;
      idx_d        = '0;
      shadow_d     = '0;
      pend_data_d  = '0;
      pending_d    = 1'b0;
      frame_done_d = 1'b0;
    end
  end

  // Pin values for the slot position the counters hold next cycle
  always_comb begin
    logic                  drive;
    logic [SEG_W-1:0]      seg_act;
    logic [NUM_DIGITS-1:0] an_act;
    drive   = (32'(cnt_d) + 32'd1) > BLANK_CYCLES;
    seg_act = '0;
    an_act  = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == IDX_W'(k)) begin
        seg_act   = drive ? shadow_d[k*SEG_W +: SEG_W] : '0;
        an_act[k] = drive && digit_en[k];
      end
    end
    an_d  = an_act  ^ {NUM_DIGITS{ACTIVE_LOW}};
    seg_d = seg_act ^ {SEG_W{ACTIVE_LOW}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      pend_data_q  <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      pend_data_q  <= pend_data_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
    end
    an_q  <= an_d;
    seg_q <= seg_d;
  end

  assign seg_out    = seg_q;
  assign an_out     = an_q;
  assign digit_idx  = idx_q;
  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule
